// File: rtl/legv8_decode_stage.sv
// rtl/legv8_decode_stage.sv - LEGv8 instruction decode stage with register file and ID/EX register
//
// Purpose:
//   Decodes one instruction per cycle from fetch. Reads two operands from the
//   architectural register file, which has a hardwired zero register and a
//   same-cycle write-back bypass. Builds the immediate for the selected format
//   and detects load-use hazards. Results are presented through a valid/ready
//   ID/EX pipeline register that can be flushed.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   fetch-side handshake for instr/pc
//   instr, pc           instruction word and its address
//   reg2loc             selects instr[4:0] (1) or instr[20:16] (0) for read port 2
//   uses_rm             read port 2 is a real source (qualifies the hazard)
//   imm_sel             immediate format: 0 D, 1 I (zero-ext), 2 CB, 3 B
//   wb_en/addr/data     register-file write port
//   ex_memread, ex_rd   load currently in EX and its destination
//   flush               drop the instruction in ID and empty the ID/EX register
//   out_valid/out_ready execution-side handshake
//   out_*               registered decode results
//   stall               load-use hazard active this cycle

module legv8_decode_stage #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic              reg2loc,
  input  logic              uses_rm,
  input  logic [1:0]        imm_sel,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_rd,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  // Register file
  logic [DATA_W-1:0] regs_q [NREGS];

  // ID/EX register
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pc_q,    out_pc_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [DATA_W-1:0] out_data1_q, out_data1_d;
  logic [DATA_W-1:0] out_data2_q, out_data2_d;
  logic [DATA_W-1:0] out_imm_q,   out_imm_d;
  logic [ADDR_W-1:0] out_rd_q,    out_rd_d;

  // Decode signals
  logic [ADDR_W-1:0] rn_idx;
  logic [ADDR_W-1:0] rm_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] imm_ext;
  logic              hz;
  logic              wb_write;
  logic              load;

  // Instruction fields are 5 bits wide; the casts truncate or zero-pad them to ADDR_W.
  assign rn_idx = ADDR_W'(instr[9:5]);
  assign rm_idx = reg2loc ? ADDR_W'(instr[4:0]) : ADDR_W'(instr[20:16]);
  assign rd_idx = ADDR_W'(instr[4:0]);

  assign wb_write = wb_en && (wb_addr != ZR);

  // Read ports. The bypass lets a register that is written back this cycle be
  // decoded in the same cycle without a stall.
  always_comb begin
    rdata1 = regs_q[rn_idx];
    if (rn_idx == ZR) begin
      rdata1 = '0;
    end else if (wb_en && (wb_addr == rn_idx)) begin
      rdata1 = wb_data;
    end
  end

  always_comb begin
    rdata2 = regs_q[rm_idx];
    if (rm_idx == ZR) begin
      rdata2 = '0;
    end else if (wb_en && (wb_addr == rm_idx)) begin
      rdata2 = wb_data;
    end
  end

  // Immediate extraction. Only the I format (arithmetic immediates) is unsigned.
  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      2'd0:    imm_ext = {{(DATA_W-9){instr[20]}},  instr[20:12]};
      2'd1:    imm_ext = {{(DATA_W-12){1'b0}},      instr[21:10]};
      2'd2:    imm_ext = {{(DATA_W-19){instr[23]}}, instr[23:5]};
      default: imm_ext = {{(DATA_W-26){instr[25]}}, instr[25:0]};
    endcase
  end

  // Load-use hazard. A load into the zero register never produces a value,
  // so it cannot create a dependency.
  assign hz = in_valid && ex_memread && (ex_rd != ZR) &&
              ((ex_rd == rn_idx) || (uses_rm && (ex_rd == rm_idx)));

  // A flush consumes and discards the input, so it must always be ready and
  // must not report a stall for an instruction that is being killed.
  assign stall    = hz && !flush;
  assign in_ready = flush || (!hz && (!out_valid_q || out_ready));
  assign load     = in_valid && in_ready && !flush;

  // ID/EX next state. All fields hold unless a new instruction is loaded.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_data1_d = out_data1_q;
    out_data2_d = out_data2_q;
    out_imm_d   = out_imm_q;
    out_rd_d    = out_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc;
      out_instr_d = instr;
      out_data1_d = rdata1;
      out_data2_d = rdata2;
      out_imm_d   = imm_ext;
      out_rd_d    = rd_idx;
    end else if (out_ready && out_valid_q) begin
      // Consumed with nothing new to load: emits a bubble.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_data1_q <= '0;
      out_data2_q <= '0;
      out_imm_q   <= '0;
      out_rd_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_data1_q <= out_data1_d;
      out_data2_q <= out_data2_d;
      out_imm_q   <= out_imm_d;
      out_rd_q    <= out_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_write) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_data1 = out_data1_q;
  assign out_data2 = out_data2_q;
  assign out_imm   = out_imm_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_legv8_decode_stage.sv
// tb/tb_legv8_decode_stage.sv - scoreboard testbench for legv8_decode_stage

module tb_legv8_decode_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] pc;
  logic              reg2loc;
  logic              uses_rm;
  logic [1:0]        imm_sel;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_memread;
  logic [ADDR_W-1:0] ex_rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [31:0]       out_instr;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;
  logic [DATA_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_rd;
  logic              stall;

  legv8_decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .reg2loc    (reg2loc),
    .uses_rm    (uses_rm),
    .imm_sel    (imm_sel),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_imm    (out_imm),
    .out_rd     (out_rd),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] imm;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mreg [32];
  int          tests;
  int          fails;
  bit          mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mread(input int idx);
    if (idx == 31) return 64'd0;
    if (wb_en && (int'(wb_addr) == idx)) return wb_data;
    return mreg[idx];
  endfunction

  function automatic logic [63:0] mimm(input logic [31:0] ins, input logic [1:0] sel);
    longint v;
    case (sel)
      2'd0: begin v = longint'(ins[20:12]); if (v >= 256) v = v - 512; end
      2'd1: v = longint'(ins[21:10]);
      2'd2: begin v = longint'(ins[23:5]); if (v >= 262144) v = v - 524288; end
      default: begin v = longint'(ins[25:0]); if (v >= 33554432) v = v - 67108864; end
    endcase
    return 64'(v);
  endfunction

  task automatic set_in(input bit v, input logic [31:0] ins, input logic [63:0] p,
                        input bit r2l, input bit urm, input logic [1:0] isel,
                        input bit we, input logic [4:0] wa, input logic [63:0] wd,
                        input bit exm, input logic [4:0] exrd, input bit fl, input bit ordy);
    in_valid = v;   instr = ins;   pc = p;
    reg2loc = r2l;  uses_rm = urm; imm_sel = isel;
    wb_en = we;     wb_addr = wa;  wb_data = wd;
    ex_memread = exm; ex_rd = exrd; flush = fl; out_ready = ordy;
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] base, input logic [4:0] rn,
                                           input logic [4:0] rm, input logic [4:0] rd);
    logic [31:0] r;
    r = base;
    r[9:5]   = rn;
    r[20:16] = rm;
    r[4:0]   = rd;
    return r;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int   rn;
    int   rm;
    bit   hz;
    bit   rdy;
    exp_t e;
    #1;
    rn  = int'(instr[9:5]);
    rm  = reg2loc ? int'(instr[4:0]) : int'(instr[20:16]);
    hz  = in_valid && ex_memread && (ex_rd != 5'd31) &&
          ((int'(ex_rd) == rn) || (uses_rm && (int'(ex_rd) == rm)));
    rdy = flush || (!hz && ((sb.size() == 0) || out_ready));
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("stall", 64'(stall), 64'(hz && !flush));
    e.pc = pc; e.instr = instr; e.d1 = mread(rn); e.d2 = mread(rm);
    e.imm = mimm(instr, imm_sel); e.rd = instr[4:0];
    #2;
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    end else begin
      if (flush) sb.delete();
      else if (in_valid && rdy) sb.push_back(e);
      if (wb_en && (wb_addr != 5'd31)) mreg[wb_addr] = wb_data;
    end
    @(negedge clk);
  endtask

  // Monitor: checks occupancy every cycle and each transfer that execution consumes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (out_valid && out_ready && (sb.size() != 0)) begin
          e = sb.pop_front();
          check("out_pc",    out_pc,           e.pc);
          check("out_instr", 64'(out_instr),   64'(e.instr));
          check("out_data1", out_data1,        e.d1);
          check("out_data2", out_data2,        e.d2);
          check("out_imm",   out_imm,          e.imm);
          check("out_rd",    64'(out_rd),      64'(e.rd));
        end
      end
    end
  end

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    logic [31:0] ins;
    logic [4:0]  a;
    tests = 0; fails = 0; mon_en = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    reset = 1'b1;
    set_in(0, 32'd0, 64'd0, 0, 0, 2'd0, 0, 5'd0, 64'd0, 0, 5'd0, 0, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc",    out_pc,         64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_data1", out_data1,      64'd0);
    check("rst_out_data2", out_data2,      64'd0);
    check("rst_out_imm",   out_imm,        64'd0);
    check("rst_out_rd",    64'(out_rd),    64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Same-cycle write-back bypass into Rn.
    set_in(1, mk_instr(32'h8B00_0000, 5'd3, 5'd1, 5'd2), 64'h100, 0, 1, 2'd1,
           1, 5'd3, 64'hDEAD_BEEF, 0, 5'd0, 0, 1);
    step();
    check("bypass_valid", 64'(out_valid), 64'd1);
    check("bypass_data1", out_data1, 64'hDEAD_BEEF);

    // Zero register ignores writes and reads as zero.
    set_in(0, 32'd0, 64'd0, 0, 0, 2'd0, 1, 5'd31, 64'h55, 0, 5'd0, 0, 1);
    step();
    set_in(1, mk_instr(32'h8B00_0000, 5'd31, 5'd31, 5'd4), 64'h104, 0, 1, 2'd0,
           0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
    step();
    check("zr_data1", out_data1, 64'd0);
    check("zr_data2", out_data2, 64'd0);

    // STUR: Rt via reg2loc, D-format offset -8.
    set_in(0, 32'd0, 64'd0, 0, 0, 2'd0, 1, 5'd5, 64'h1234, 0, 5'd0, 0, 1);
    step();
    ins = mk_instr(32'hF800_0000, 5'd2, 5'd9, 5'd5);
    ins[20:12] = 9'h1F8;
    set_in(1, ins, 64'h108, 1, 1, 2'd0, 0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
    step();
    check("stur_data2", out_data2, 64'h1234);
    check("stur_imm",   out_imm,   64'hFFFF_FFFF_FFFF_FFF8);

    // Load-use: one bubble, then accepted once the load clears.
    set_in(1, mk_instr(32'h8B00_0000, 5'd7, 5'd1, 5'd8), 64'h10C, 0, 1, 2'd1,
           0, 5'd0, 64'd0, 1, 5'd7, 0, 1);
    step();
    check("lu_bubble", 64'(out_valid), 64'd0);
    ex_memread = 1'b0;
    step();
    check("lu_accept", 64'(out_valid), 64'd1);

    // Backpressure: fields hold for three cycles.
    set_in(1, mk_instr(32'h8B00_0000, 5'd1, 5'd2, 5'd3), 64'h110, 0, 1, 2'd1,
           0, 5'd0, 64'd0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_pc", out_pc, 64'h10C);
    end
    out_ready = 1'b1;
    step();
    check("bp_new_pc", out_pc, 64'h110);

    // Flush with a valid ID/EX entry and a valid input.
    set_in(1, mk_instr(32'h8B00_0000, 5'd1, 5'd2, 5'd3), 64'h114, 0, 1, 2'd1,
           0, 5'd0, 64'd0, 0, 5'd0, 1, 0);
    step();
    check("flush_valid", 64'(out_valid), 64'd0);

    // Reset during a stall, then read every register back.
    set_in(1, mk_instr(32'h8B00_0000, 5'd5, 5'd1, 5'd8), 64'h118, 0, 1, 2'd1,
           0, 5'd0, 64'd0, 1, 5'd5, 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ex_memread = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst_stall_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 32; i += 2) begin
      set_in(1, mk_instr(32'h8B00_0000, 5'(i), 5'(i + 1), 5'd0), 64'(i), 0, 1, 2'd1,
             0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
      step();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      ins = mk_instr($urandom, pick(), pick(), pick());
      a = pick();
      set_in($urandom_range(0, 3) != 0, ins, {$urandom, $urandom},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, {$urandom, $urandom},
             $urandom_range(0, 3) == 0, pick(), $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
